// File: rtl/fifo_pkg.sv
// Shared constants for the byte-wide FIFO: uio pin bit positions and output-enable mask.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam int unsigned PUSH_BIT   = 0;
  localparam int unsigned POP_BIT    = 1;

  localparam int unsigned FULL_BIT   = 7;
  localparam int unsigned EMPTY_BIT  = 6;
  localparam int unsigned AFULL_BIT  = 5;
  localparam int unsigned AEMPTY_BIT = 4;
  localparam int unsigned OVF_BIT    = 3;
  localparam int unsigned UNF_BIT    = 2;

  // uio[7:2] are status outputs, uio[1:0] are push/pop inputs.
  localparam logic [7:0] UIO_OE_MASK = 8'hFC;

endpackage

// File: rtl/fifo_mem.sv
// Depth x DataWidth register file: one synchronous write port, one combinational read port.
module fifo_mem #(
  parameter int unsigned IndexWidth = 4,
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned Depth      = 1 << IndexWidth
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IndexWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0]  wdata_i,
  input  logic [IndexWidth-1:0] raddr_i,
  output logic [DataWidth-1:0]  rdata_o
);

  // Contents are never reset; the top masks the read data while empty.
  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_core.sv
// Show-ahead byte FIFO on the TinyTapeout pin interface: pointers, status flags and pin mapping.
module fifo_core
  import fifo_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH            = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD  = 2,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
  localparam int unsigned PtrW  = INDEX_WIDTH + 1;

  localparam logic [PtrW-1:0] FullLevel = PtrW'(DEPTH);
  localparam logic [PtrW-1:0] AfLevel   = PtrW'(DEPTH - ALMOST_FULL_THRESHOLD);
  localparam logic [PtrW-1:0] AeLevel   = PtrW'(ALMOST_EMPTY_THRESHOLD);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic [PtrW-1:0] count;
  logic            empty, full, almost_full, almost_empty;
  logic            push, pop, push_ok, pop_ok;
  logic [7:0]      rd_data;

  logic unused_uio;
  assign unused_uio = ^uio_in[7:2];

  assign push = uio_in[PUSH_BIT];
  assign pop  = uio_in[POP_BIT];

  // Pointer difference wraps modulo 2^PtrW, so the extra MSB separates full from empty.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == FullLevel);
  assign almost_full  = (count >= AfLevel);
  assign almost_empty = (count <= AeLevel);

  // A pop while full frees a slot in the same cycle, letting the push through.
  assign pop_ok  = ena & pop & ~empty;
  assign push_ok = ena & push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (ena & push & full & ~pop_ok) begin
      overflow_d = 1'b1;
    end
    // A pop paired with a push on an empty FIFO is simply dropped, not an underflow.
    if (ena & pop & empty & ~push) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .IndexWidth (INDEX_WIDTH),
    .DataWidth  (DATA_WIDTH),
    .Depth      (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q[INDEX_WIDTH-1:0]),
    .wdata_i (ui_in),
    .raddr_i (rd_ptr_q[INDEX_WIDTH-1:0]),
    .rdata_o (rd_data)
  );

  assign uo_out = empty ? 8'h00 : rd_data;

  always_comb begin
    uio_out             = '0;
    uio_out[FULL_BIT]   = full;
    uio_out[EMPTY_BIT]  = empty;
    uio_out[AFULL_BIT]  = almost_full;
    uio_out[AEMPTY_BIT] = almost_empty;
    uio_out[OVF_BIT]    = overflow_q;
    uio_out[UNF_BIT]    = underflow_q;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_fifo_core.sv
// Directed self-checking bench for fifo_core with DEPTH=4, AF threshold 2, AE threshold 1.
module tb_fifo_core;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_core #(
    .INDEX_WIDTH            (2),
    .ALMOST_FULL_THRESHOLD  (2),
    .ALMOST_EMPTY_THRESHOLD (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flag order: full, empty, almost_full, almost_empty, overflow, underflow.
  task automatic check_state(input string tag, input logic [7:0] exp_data,
                             input logic [5:0] exp_flags);
    check({tag, ".data"}, uo_out, exp_data);
    check({tag, ".flags"}, {2'b00, uio_out[7:2]}, {2'b00, exp_flags});
  endtask

  // One clock with the given strobes; inputs return to idle #1 after the edge.
  task automatic cycle(input logic do_push, input logic do_pop, input logic [7:0] data);
    ui_in  = data;
    uio_in = {6'b000000, do_pop, do_push};
    @(posedge clk);
    #1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 6'b010100);
    check("uio_oe", uio_oe, 8'hFC);
    check("uio_out_low", {6'b000000, uio_out[1:0]}, 8'h00);
    rst = 1'b0;

    // Fill to full.
    cycle(1'b1, 1'b0, 8'hA1);
    check_state("push1", 8'hA1, 6'b000100);
    cycle(1'b1, 1'b0, 8'hA2);
    check_state("push2", 8'hA1, 6'b001000);
    cycle(1'b1, 1'b0, 8'hA3);
    check_state("push3", 8'hA1, 6'b001000);
    cycle(1'b1, 1'b0, 8'hA4);
    check_state("push4", 8'hA1, 6'b101000);

    // Overflow drops the byte and sets the sticky flag.
    cycle(1'b1, 1'b0, 8'hFF);
    check_state("ovf", 8'hA1, 6'b101010);

    cycle(1'b0, 1'b1, 8'h00);
    check_state("pop1", 8'hA2, 6'b001010);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("pop2", 8'hA3, 6'b001010);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("pop3", 8'hA4, 6'b000110);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("pop4", 8'h00, 6'b010110);

    // Underflow on empty, then push+pop on empty only pushes.
    cycle(1'b0, 1'b1, 8'h00);
    check_state("unf", 8'h00, 6'b010111);
    cycle(1'b1, 1'b1, 8'h77);
    check_state("pp_empty", 8'h77, 6'b000111);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("pp_empty_drain", 8'h00, 6'b010111);

    // Push+pop on a full FIFO keeps it full and inserts at the tail.
    cycle(1'b1, 1'b0, 8'hA1);
    cycle(1'b1, 1'b0, 8'hA2);
    cycle(1'b1, 1'b0, 8'hA3);
    cycle(1'b1, 1'b0, 8'hA4);
    check_state("refill", 8'hA1, 6'b101011);
    cycle(1'b1, 1'b1, 8'h55);
    check_state("pp_full", 8'hA2, 6'b101011);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("drain1", 8'hA3, 6'b001011);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("drain2", 8'hA4, 6'b001011);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("drain3", 8'h55, 6'b000111);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("drain4", 8'h00, 6'b010111);

    // Interleaved streaming across pointer wrap: 10 bytes C0..C9 in order.
    cycle(1'b1, 1'b0, 8'hC0);
    cycle(1'b1, 1'b0, 8'hC1);
    check_state("wrap_prime", 8'hC0, 6'b001011);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 8'hC2 + 8'(i));
      check("wrap_head", uo_out, 8'hC1 + 8'(i));
    end
    check_state("wrap_end", 8'hC8, 6'b001011);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("wrap_pop1", 8'hC9, 6'b000111);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("wrap_pop2", 8'h00, 6'b010111);

    // Asynchronous reset mid-stream clears everything immediately.
    cycle(1'b1, 1'b0, 8'hD0);
    cycle(1'b1, 1'b0, 8'hD1);
    check_state("pre_rst", 8'hD0, 6'b001011);
    #2;
    rst = 1'b1;
    #1;
    check_state("mid_rst", 8'h00, 6'b010100);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("post_rst", 8'h00, 6'b010100);

    // ena=0 freezes state.
    ena = 1'b0;
    cycle(1'b1, 1'b0, 8'hE0);
    check_state("ena_off_push", 8'h00, 6'b010100);
    cycle(1'b0, 1'b1, 8'h00);
    check_state("ena_off_pop", 8'h00, 6'b010100);
    ena = 1'b1;
    cycle(1'b1, 1'b0, 8'hE1);
    check_state("ena_on_push", 8'hE1, 6'b000100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
